// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector.
// Mealy match output, overlap/non-overlap modes and a valid-qualified input.
// Optional feature macro: SEQDET_MATCH_CNT_EN enables the saturating hit
// counter; when undefined, match_cnt is tied to zero.
module seq_detector_param #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_load,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  input  logic                           in_valid,
  input  logic                           in_bit,
  output logic                           match,
  output logic [CNT_W-1:0]               match_cnt,
  output logic                           cfg_err
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  // Configuration registers
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LW-1:0]      len_q, len_d;
  logic               overlap_q, overlap_d;
  logic               cfg_err_q, cfg_err_d;

  // History keeps only MAX_LEN-1 bits: the current in_bit supplies the
  // newest window position, so the oldest history bit would never be read.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;

  logic [31:0]        len_ext;
  logic [31:0]        fill_ext;
  logic [31:0]        cfg_len_ext;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] win;
  logic               len_ok;
  logic               fill_ok;
  logic               win_eq;
  logic               hit;

  assign len_ext     = {{(32-LW){1'b0}}, len_q};
  assign fill_ext    = {{(32-LW){1'b0}}, fill_q};
  assign cfg_len_ext = {{(32-LW){1'b0}}, cfg_len};

  // Window compare against the low len_q bits of the stored pattern
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < len_ext);
    end
    win     = {hist_q, in_bit};
    len_ok  = (len_ext >= 32'd1) && (len_ext <= MAX_LEN);
    fill_ok = (fill_ext + 32'd1) >= len_ext;
    win_eq  = ((win ^ pattern_q) & mask) == '0;
    hit     = !rst && in_valid && !cfg_load && len_ok && fill_ok && win_eq;
  end

  assign match   = hit;
  assign cfg_err = cfg_err_q;

  // Next-state: cfg_load outranks bit acceptance; hits in non-overlap mode restart the fill
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    cfg_err_d = cfg_err_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
      cfg_err_d = !((cfg_len_ext >= 32'd1) && (cfg_len_ext <= MAX_LEN));
      hist_d    = '0;
      fill_d    = '0;
    end else if (in_valid) begin
      hist_d = {hist_q[MAX_LEN-3:0], in_bit};
      if (hit && !overlap_q) begin
        fill_d = '0;
      end else if (fill_ext < MAX_LEN) begin
        fill_d = fill_q + LW'(1);
      end
    end
  end

  // State registers with synchronous reset to the default 1010 detector
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= MAX_LEN'(4'b1010);
      len_q     <= LW'(4);
      overlap_q <= 1'b0;
      cfg_err_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      cfg_err_q <= cfg_err_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating hit counter, cleared by cfg_load
  always_comb begin
    cnt_d = cnt_q;
    if (cfg_load) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios plus a
// randomized run, all compared with a queue-based reference model.
module tb_seq_detector_param;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 2;
  localparam int          CMAX    = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             cfg_load;
  logic [7:0]       cfg_pattern;
  logic [3:0]       cfg_len;
  logic             cfg_overlap;
  logic             in_valid;
  logic             in_bit;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             cfg_err;

  int n_checks;
  int n_fail;

  // Reference model state: accepted bits since last clear, and how many
  // of them are "fresh" (usable for the next hit).
  bit         m_q[$];
  int         m_fresh;
  logic [7:0] m_pat;
  int         m_len;
  logic       m_ov;
  int         m_cnt;
  logic       m_err;
  logic       exp_match;

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .match      (match),
    .match_cnt  (match_cnt),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_hit();
    logic bk;
    if (rst || cfg_load || !in_valid) return 1'b0;
    if (m_len < 1 || m_len > int'(MAX_LEN)) return 1'b0;
    if (m_fresh + 1 < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      bk = (k == 0) ? in_bit : m_q[m_q.size() - k];
      if (bk !== m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_update();
    logic h;
    h = model_hit();
    if (rst) begin
      m_pat = 8'h0A; m_len = 4; m_ov = 1'b0; m_q.delete();
      m_fresh = 0; m_cnt = 0; m_err = 1'b0;
    end else if (cfg_load) begin
      m_pat = cfg_pattern; m_len = int'(cfg_len); m_ov = cfg_overlap;
      m_q.delete(); m_fresh = 0; m_cnt = 0;
      m_err = !(cfg_len >= 4'd1 && int'(cfg_len) <= int'(MAX_LEN));
    end else if (in_valid) begin
      m_q.push_back(in_bit);
      if (m_q.size() > 32) void'(m_q.pop_front());
      if (h && !m_ov) m_fresh = 0;
      else m_fresh++;
      if (h && m_cnt < CMAX) m_cnt++;
    end
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef SEQDET_MATCH_CNT_EN
    return CNT_W'(m_cnt);
`else
    return '0;
`endif
  endfunction

  // Apply one cycle of inputs at the falling edge; expected match is ready after settling.
  task automatic drive(input logic r, input logic ld, input logic v, input logic b,
                       input logic [7:0] pat, input logic [3:0] ln, input logic ov);
    @(negedge clk);
    rst = r; cfg_load = ld; in_valid = v; in_bit = b;
    cfg_pattern = pat; cfg_len = ln; cfg_overlap = ov;
    #2;
    exp_match = model_hit();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
      n_checks++;
      if (match !== 1'b0) begin
        n_fail++; $display("FAIL reset_match: match=%b expected 0", match);
      end
      tick();
    end
    n_checks++;
    if (match_cnt !== '0) begin
      n_fail++; $display("FAIL reset_cnt: match_cnt=%0d expected 0", match_cnt);
    end
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_cfg_err: cfg_err=%b expected 0", cfg_err);
    end
  endtask

  task automatic test_default_nonoverlap();
    logic [7:0] bits;
    logic [7:0] obs;
    bits = 8'b1010_1010;
    obs  = '0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b1, bits[7-i], 8'h00, 4'd0, 1'b0);
      obs[i] = match;
      n_checks++;
      if (match !== exp_match) begin
        n_fail++; $display("FAIL default_match bit%0d: match=%b expected %b", i, match, exp_match);
      end
      tick();
    end
    n_checks++;
    if (obs !== 8'b1000_1000) begin
      n_fail++; $display("FAIL default_hits: mask=%b expected 10001000", obs);
    end
    n_checks++;
    if (match_cnt !== exp_cnt()) begin
      n_fail++; $display("FAIL default_cnt: match_cnt=%0d expected %0d", match_cnt, exp_cnt());
    end
  endtask

  task automatic test_overlap();
    logic [5:0] bits;
    logic [5:0] obs;
    bits = 6'b101010;
    obs  = '0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h0A, 4'd4, 1'b1);
    n_checks++;
    if (match !== 1'b0) begin
      n_fail++; $display("FAIL overlap_load_match: match=%b expected 0", match);
    end
    tick();
    n_checks++;
    if (match_cnt !== '0) begin
      n_fail++; $display("FAIL overlap_load_cnt: match_cnt=%0d expected 0", match_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b1, bits[5-i], 8'h00, 4'd0, 1'b0);
      obs[i] = match;
      n_checks++;
      if (match !== exp_match) begin
        n_fail++; $display("FAIL overlap_match bit%0d: match=%b expected %b", i, match, exp_match);
      end
      tick();
    end
    n_checks++;
    if (obs !== 6'b101000) begin
      n_fail++; $display("FAIL overlap_hits: mask=%b expected 101000", obs);
    end
    n_checks++;
    if (match_cnt !== exp_cnt()) begin
      n_fail++; $display("FAIL overlap_cnt: match_cnt=%0d expected %0d", match_cnt, exp_cnt());
    end
  endtask

  task automatic test_gap();
    logic [10:0] v;
    logic [10:0] b;
    logic [10:0] obs;
    v   = 11'b11111_000_111;
    b   = 11'b10100_111_101;
    obs = '0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 4'd8, 1'b0);
    tick();
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 1'b0, v[10-i], b[10-i], 8'h00, 4'd0, 1'b0);
      obs[i] = match;
      n_checks++;
      if (match !== exp_match) begin
        n_fail++; $display("FAIL gap_match cyc%0d: match=%b expected %b", i, match, exp_match);
      end
      tick();
    end
    n_checks++;
    if (obs !== 11'b100_0000_0000) begin
      n_fail++; $display("FAIL gap_hits: mask=%b expected 10000000000", obs);
    end
  endtask

  task automatic test_cfg_err();
    logic [3:0] bad_len [2];
    bad_len[0] = 4'd0;
    bad_len[1] = 4'd12;
    for (int t = 0; t < 2; t++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, bad_len[t], 1'b1);
      tick();
      n_checks++;
      if (cfg_err !== 1'b1) begin
        n_fail++; $display("FAIL cfg_err_set len%0d: cfg_err=%b expected 1", bad_len[t], cfg_err);
      end
      for (int i = 0; i < 12; i++) begin
        drive(1'b0, 1'b0, 1'b1, (t == 1) ? 1'b1 : 1'($urandom_range(1)), 8'h00, 4'd0, 1'b0);
        n_checks++;
        if (match !== 1'b0) begin
          n_fail++; $display("FAIL cfg_err_match len%0d cyc%0d: match=%b expected 0", bad_len[t], i, match);
        end
        tick();
      end
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 4'd3, 1'b0);
    tick();
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL cfg_err_clear: cfg_err=%b expected 0", cfg_err);
    end
  endtask

  task automatic test_len1_saturate();
    logic [CNT_W-1:0] want [5];
`ifdef SEQDET_MATCH_CNT_EN
    want = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
    want = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 4'd1, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 4'd0, 1'b0);
      n_checks++;
      if (match !== 1'b1) begin
        n_fail++; $display("FAIL len1_match bit%0d: match=%b expected 1", i, match);
      end
      tick();
      n_checks++;
      if (match_cnt !== want[i]) begin
        n_fail++; $display("FAIL len1_cnt bit%0d: match_cnt=%0d expected %0d", i, match_cnt, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] pre;
    logic [4:0] post;
    logic [4:0] obs;
    pre  = 3'b101;
    post = 5'b01010;
    obs  = '0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, pre[2-i], 8'h00, 4'd0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
    n_checks++;
    if (match !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_in_reset: match=%b expected 0", match);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, post[4-i], 8'h00, 4'd0, 1'b0);
      obs[i] = match;
      n_checks++;
      if (match !== exp_match) begin
        n_fail++; $display("FAIL rstmid_match bit%0d: match=%b expected %b", i, match, exp_match);
      end
      tick();
    end
    n_checks++;
    if (obs !== 5'b10000) begin
      n_fail++; $display("FAIL rstmid_hits: mask=%b expected 10000", obs);
    end
  endtask

  task automatic test_random();
    int         sel;
    logic [3:0] ln;
    for (int i = 0; i < 1500; i++) begin
      sel = int'($urandom_range(99));
      if (sel < 2) begin
        drive(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
              8'($urandom), 4'd0, 1'b0);
      end else if (sel < 6) begin
        ln = ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(4, 1));
        drive(1'b0, 1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)),
              8'($urandom), ln, 1'($urandom_range(1)));
      end else begin
        drive(1'b0, 1'b0, ($urandom_range(9) < 7), 1'($urandom_range(1)), 8'h00, 4'd0, 1'b0);
      end
      n_checks++;
      if (match !== exp_match) begin
        n_fail++; $display("FAIL rand_match cyc%0d: match=%b expected %b", i, match, exp_match);
      end
      tick();
      n_checks++;
      if (match_cnt !== exp_cnt()) begin
        n_fail++; $display("FAIL rand_cnt cyc%0d: match_cnt=%0d expected %0d", i, match_cnt, exp_cnt());
      end
      n_checks++;
      if (cfg_err !== m_err) begin
        n_fail++; $display("FAIL rand_cfg_err cyc%0d: cfg_err=%b expected %b", i, cfg_err, m_err);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; cfg_load = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    m_pat = 8'h0A; m_len = 4; m_ov = 1'b0; m_fresh = 0; m_cnt = 0; m_err = 1'b0;
    exp_match = 1'b0;
    test_reset();
    test_default_nonoverlap();
    test_overlap();
    test_gap();
    test_cfg_err();
    test_len1_saturate();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Runtime-programmable serial bit-pattern detector with a Mealy output. It generalises the fixed 1010 detector in three ways: pattern length up to MAX_LEN, a selectable overlap or non-overlap mode, and a valid-qualified input. It sits on a serial data path after bit recovery and reports pattern hits to control logic. It also keeps a saturating hit counter.

Parameters:
MAX_LEN, 8, maximum pattern length in bits; legal range 4..32.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, synchronous, active-high.
cfg_load  input  1  one-cycle strobe; captures cfg_pattern, cfg_len and cfg_overlap.
cfg_pattern  input  MAX_LEN  pattern bits; pattern[len-1] is the first bit on the line, pattern[0] the last.
cfg_len  input  $clog2(MAX_LEN+1)  pattern length in bits.
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
in_valid  input  1  in_bit is sampled only when high.
in_bit  input  1  serial data bit.
match  output  1  Mealy hit flag, combinational, asserted in the cycle the final pattern bit is presented.
match_cnt  output  CNT_W  saturating count of hits.
cfg_err  output  1  registered; high while the stored length is illegal.

Behaviour:
- Reset (rst=1 at clk edge):
  - pattern_r=1010 in bits [3:0], upper bits 0; len_r=4; overlap_r=0.
  - History register = 0; fill counter = 0.
  - match_cnt=0; cfg_err=0.
  - match is low during and after reset until a real hit occurs.
- Registers: history hist_r[MAX_LEN-1:0], holding the most recent bit at [0]; fill counter fill_r, saturating at MAX_LEN.
- Window compare:
  - win = {hist_r, in_bit}, truncated to the low len_r bits.
  - hit = in_valid && !cfg_load && len_ok && (fill_r >= len_r-1) && (win[len_r-1:0] == pattern_r[len_r-1:0]).
  - len_ok = (1 <= len_r <= MAX_LEN).
  - match = hit, combinational from state and inputs with no added latency.
- Accepted bit (in_valid=1, cfg_load=0):
  - hist_r <= {hist_r[MAX_LEN-2:0], in_bit}.
  - fill_r <= min(fill_r+1, MAX_LEN).
- Hit in non-overlap mode: fill_r <= 0. The history contents are don't-care, so the next hit needs len_r fresh bits.
- Hit in overlap mode: fill_r keeps saturating as for a normal accepted bit, so the suffix can start the next hit.
- in_valid=0: hist_r and fill_r hold, and match is 0. Gaps of any length do not break a partial sequence.
- len_r=1: every valid bit equal to pattern_r[0] is a hit, in either mode.
- cfg_load=1:
  - Captures pattern_r, len_r and overlap_r; clears hist_r, fill_r and match_cnt.
  - The in_bit presented in that cycle is discarded and match is forced to 0.
  - cfg_err <= !(1 <= cfg_len <= MAX_LEN).
  - cfg_load has priority over in_valid; rst has priority over everything.
- Illegal length (cfg_err=1): match is held at 0 and bits are still shifted in. The next cfg_load with a legal length clears cfg_err.
- match_cnt increments by 1 on each hit and saturates at 2^CNT_W-1 without wrapping.
- Reset mid-sequence discards any partial pattern; the first hit after reset needs a full fresh pattern.
- Mode change takes effect only through cfg_load; overlap_r is not live-switchable.

Optional Feature:
- Macro SEQDET_MATCH_CNT_EN.
- Defined: match_cnt is implemented as described above.
- Undefined: the counter logic is omitted and match_cnt is tied to 0. The port list is unchanged; match and all other behaviour are identical.

Test Plan:
- Reset defaults, in_valid=1, bits 1,0,1,0,1,0,1,0 → match high on bits 4 and 8 only; match_cnt=2.
- cfg_load with len=4, pattern=1010, overlap=1, then bits 1,0,1,0,1,0 → match on bits 4 and 6; match_cnt=2. The cfg_load cycle itself gives match=0 and clears the count.
- cfg_load with len=8, pattern=8'hA5, non-overlap, stream 1010_0101 with in_valid low for 3 cycles after bit 5 → single match on bit 8, none during the gap.
- cfg_load with len=0 → cfg_err=1 next cycle; any stream gives match=0. Reload with len=3 → cfg_err=0.
- CNT_W=2, len=1, pattern=1, five consecutive 1s → match every valid cycle; match_cnt sequence 1,2,3,3,3.
- Default config, bits 1,0,1, then rst for 1 cycle, then 0 → no match; bits 1,0,1,0 then give a match on the 4th bit.
